axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter C_M_TARGET_BASE_ADDR, default 32'h0000_0000, byte address of the first register accessed.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 32, address width.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32, data width (32 only).
REQ-004 Parameter C_M_TRANSACTIONS_NUM, default 4, number of writes, and of reads (1..255).
REQ-005 Parameter C_M_START_DATA_VALUE, default 32'hAA00_0000, data of the first write.
REQ-006 Ports: M_AXI_ACLK in 1 clock; M_AXI_ARESETN in 1 reset; one clock, reset asynchronous active-low.
REQ-007 WCOMPLETE out 1, all writes done; RCOMPLETE out 1, all reads done; ERROR out 1, sticky failure flag.
REQ-008 M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-009 M_AXI_WDATA out DATA_W; M_AXI_WSTRB out DATA_W/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-010 M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
REQ-011 M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
REQ-012 M_AXI_RDATA in DATA_W; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-013 FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE; IDLE moves to WR_ADDR_DATA on the first clock after reset release (no start input).
REQ-014 Transaction i (0-based) uses address C_M_TARGET_BASE_ADDR + 4*i, write data C_M_START_DATA_VALUE + i; WSTRB all ones; AWPROT = ARPROT = 3'b000.
REQ-015 WR_ADDR_DATA: AWVALID and WVALID rise together; each drops the cycle after its own VALID&&READY; address/data held stable while VALID high; advance to WR_RESP when both accepted (either order or same cycle).
REQ-016 WR_RESP: BREADY high; on BVALID, BREADY drops, write counter increments; next WR_ADDR_DATA if counter < N, else RD_ADDR.
REQ-017 At most one outstanding transaction; VALIDs never depend combinationally on READYs.
REQ-018 WCOMPLETE rises the cycle after the Nth B handshake and stays high until reset.
REQ-019 RD_ADDR: ARVALID high until ARREADY handshake, then RD_DATA with RREADY high; on RVALID compare RDATA to expected write data i, increment read counter; next RD_ADDR or DONE.
REQ-020 RCOMPLETE rises the cycle after the Nth R handshake and stays high; DONE is terminal until reset.
REQ-021 ERROR sets (sticky) on BRESP != 2'b00, RRESP != 2'b00, or RDATA mismatch; flow continues regardless.
REQ-022 Counters sized for N, no wrap-around; extra BVALID/RVALID outside response states ignored.

Reset
REQ-023 ARESETN low asynchronously forces state IDLE, counters 0, all VALID/READY outputs 0, WCOMPLETE/RCOMPLETE/ERROR 0, addresses/WDATA 0.
REQ-024 Reset asserted mid-transaction aborts immediately; sequence restarts from transaction 0 after release.

Structure
REQ-025 Shared package axi_lite_pkg holds FSM state enum and RESP_OKAY/RESP_SLVERR constants.
REQ-026 Single flat module; no sub-modules.

Verification
REQ-027 Zero-wait slave, defaults -> writes AA000000..AA000003 to 0x0,0x4,0x8,0xC; WCOMPLETE then RCOMPLETE high; ERROR 0.
REQ-028 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, AWVALID held with AWADDR stable; one BREADY per write.
REQ-029 Slave returns BRESP=2'b10 on write 2 -> ERROR sticks 1; WCOMPLETE and RCOMPLETE still assert.
REQ-030 Read 1 returns 32'hDEADBEEF -> ERROR 1 after that R handshake.
REQ-031 ARESETN pulsed low during write 1 -> outputs zero asynchronously; restart at address 0x0, data AA000000.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: FSM state encoding and response codes shared by the AXI-Lite master and its bench.
package axi_lite_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: writes N incrementing words to consecutive registers, reads them back and flags any mismatch or error response.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h0000_0000,
  parameter int          C_M_AXI_ADDR_WIDTH   = 32,
  parameter int          C_M_AXI_DATA_WIDTH   = 32,
  parameter int          C_M_TRANSACTIONS_NUM = 4,
  parameter logic [31:0] C_M_START_DATA_VALUE = 32'hAA00_0000
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  output logic                              WCOMPLETE,
  output logic                              RCOMPLETE,
  output logic                              ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int N  = C_M_TRANSACTIONS_NUM;
  localparam int CW = $clog2(N + 1);
  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] i);
    return AW'(C_M_TARGET_BASE_ADDR) + (AW'(i) << 2);
  endfunction
  function automatic logic [DW-1:0] data_of(input logic [CW-1:0] i);
    return DW'(C_M_START_DATA_VALUE + 32'(i));
  endfunction
  state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, wnext, rnext;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic wcomplete_q, wcomplete_d, rcomplete_q, rcomplete_d, error_q, error_d;
  logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  assign wnext = wcnt_q + 1'b1;
  assign rnext = rcnt_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    wcomplete_d = wcomplete_q;
    rcomplete_d = rcomplete_q;
    error_d     = error_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        state_d   = WR_ADDR_DATA;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        awaddr_d  = addr_of(wcnt_q);
        wdata_d   = data_of(wcnt_q);
      end
      WR_ADDR_DATA: begin
        // each channel retires independently; move on once both have
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (M_AXI_BVALID) begin
        bready_d = 1'b0;
        wcnt_d   = wnext;
        error_d  = error_q | (M_AXI_BRESP != RESP_OKAY);
        if (wnext < CW'(N)) begin
          state_d   = WR_ADDR_DATA;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = addr_of(wnext);
          wdata_d   = data_of(wnext);
        end else begin
          state_d     = RD_ADDR;
          wcomplete_d = 1'b1;
          arvalid_d   = 1'b1;
          araddr_d    = addr_of(rcnt_q);
        end
      end
      RD_ADDR: if (M_AXI_ARREADY) begin
        state_d   = RD_DATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      RD_DATA: if (M_AXI_RVALID) begin
        rready_d = 1'b0;
        rcnt_d   = rnext;
        error_d  = error_q | (M_AXI_RRESP != RESP_OKAY) | (M_AXI_RDATA != data_of(rcnt_q));
        if (rnext < CW'(N)) begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = addr_of(rnext);
        end else begin
          state_d     = DONE;
          rcomplete_d = 1'b1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wcomplete_q  <= 1'b0;
      rcomplete_q  <= 1'b0;
      error_q      <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      wcomplete_q  <= wcomplete_d;
      rcomplete_q  <= rcomplete_d;
      error_q      <= error_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
    end
  end
  assign WCOMPLETE     = wcomplete_q;
  assign RCOMPLETE     = rcomplete_q;
  assign ERROR         = error_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: randomized AXI-Lite slave plus a transaction-level reference for the write/read-back master.
module tb_axi_lite_master;
  localparam int          N     = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] START = 32'hAA00_0000;
  logic clk = 1'b0, rst_n = 1'b1;
  logic wcomplete, rcomplete, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  always #5 clk = ~clk;
  axi_lite_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .WCOMPLETE(wcomplete), .RCOMPLETE(rcomplete), .ERROR(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  int n_checks = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  int aw_lo, aw_hi, w_lo, w_hi, ar_lo, ar_hi, aw_wait, w_wait, ar_wait, berr_idx, rbad_idx;
  logic aw_done, w_done, b_hs, ar_done, r_hs;
  logic [31:0] last_aw, last_w, last_ar;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wa_log[$], wd_log[$], ra_log[$];
  int bhs_cyc[$], rhs_cyc[$];
  int cyc = 0, wc_cyc, rc_cyc, err_cyc, bready_rises;
  bit w_first_drop;
  logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  function automatic logic [31:0] qw(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100;
  endfunction
  // Monitor: samples pre-edge values, checks handshake rules, logs completed transfers.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br} = '0;
    end else begin
      if (p_awv && !p_awr) begin chk("awvalid_hold", awvalid, 1); chk("awaddr_stable", awaddr, p_awaddr); end
      if (p_wv && !p_wr) begin chk("wvalid_hold", wvalid, 1); chk("wdata_stable", wdata, p_wdata); end
      if (p_arv && !p_arr) begin chk("arvalid_hold", arvalid, 1); chk("araddr_stable", araddr, p_araddr); end
      if (awvalid && !p_awv) begin
        chk("aw_w_together", wvalid, 1);
        chk("one_outstanding_wr", wa_log.size(), bhs_cyc.size());
      end
      if (arvalid && !p_arv) begin
        chk("ar_after_writes", bhs_cyc.size(), N);
        chk("one_outstanding_rd", ra_log.size(), rhs_cyc.size());
      end
      if (awvalid && !wvalid) w_first_drop = 1;
      if (bready && !p_br) bready_rises++;
      if (awvalid && awready) begin
        chk("awprot", awprot, 0);
        wa_log.push_back(awaddr); last_aw = awaddr; aw_done = 1; aw_wait = $urandom_range(aw_lo, aw_hi);
      end
      if (wvalid && wready) begin
        chk("wstrb", wstrb, 4'hF);
        wd_log.push_back(wdata); last_w = wdata; w_done = 1; w_wait = $urandom_range(w_lo, w_hi);
      end
      if (bvalid && bready) begin bhs_cyc.push_back(cyc); b_hs = 1; end
      if (arvalid && arready) begin
        chk("arprot", arprot, 0);
        ra_log.push_back(araddr); last_ar = araddr; ar_done = 1; ar_wait = $urandom_range(ar_lo, ar_hi);
      end
      if (rvalid && rready) begin rhs_cyc.push_back(cyc); r_hs = 1; end
      if (wcomplete && wc_cyc < 0) wc_cyc = cyc;
      if (rcomplete && rc_cyc < 0) rc_cyc = cyc;
      if (error && err_cyc < 0) err_cyc = cyc;
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br} = {awvalid, awready, wvalid, wready, arvalid, arready, bready};
      {p_awaddr, p_wdata, p_araddr} = {awaddr, wdata, araddr};
    end
  end
  // Slave: drives its outputs on the falling edge; a word is stored once both AW and W are accepted.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      {awready, wready, bvalid, arready, rvalid} = '0;
      {bresp, rresp, rdata} = '0;
      {aw_done, w_done, b_hs, ar_done, r_hs} = '0;
      aw_wait = $urandom_range(aw_lo, aw_hi);
      w_wait = $urandom_range(w_lo, w_hi);
      ar_wait = $urandom_range(ar_lo, ar_hi);
    end else begin
      awready = (aw_wait == 0); if (awvalid && aw_wait > 0) aw_wait--;
      wready = (w_wait == 0); if (wvalid && w_wait > 0) w_wait--;
      arready = (ar_wait == 0); if (arvalid && ar_wait > 0) ar_wait--;
      if (b_hs) begin bvalid = 0; b_hs = 0; end
      else if (aw_done && w_done && !bvalid) begin
        mem[last_aw] = last_w;
        bvalid = 1;
        bresp = (bhs_cyc.size() == berr_idx) ? 2'b10 : 2'b00;
        aw_done = 0; w_done = 0;
      end
      if (r_hs) begin rvalid = 0; r_hs = 0; end
      else if (ar_done && !rvalid) begin
        rvalid = 1;
        rdata = (rhs_cyc.size() == rbad_idx) ? 32'hDEAD_BEEF : (mem.exists(last_ar) ? mem[last_ar] : 32'h0);
        rresp = 2'b00;
        ar_done = 0;
      end
    end
  end
  task automatic set_delays(input int a0, input int a1, input int w0, input int w1, input int r0, input int r1);
    aw_lo = a0; aw_hi = a1; w_lo = w0; w_hi = w1; ar_lo = r0; ar_hi = r1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    wa_log.delete(); wd_log.delete(); ra_log.delete(); bhs_cyc.delete(); rhs_cyc.delete();
    wc_cyc = -1; rc_cyc = -1; err_cyc = -1; bready_rises = 0; w_first_drop = 0;
    @(negedge clk);
    #1 rst_n = 1;
  endtask
  // Reference: transaction i writes START+i to BASE+4i, then the same words are read back in order.
  task automatic run_and_check(input string tag, input bit exp_err);
    for (int c = 0; c < 3000 && rcomplete !== 1'b1; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_rcomplete"}, rcomplete, 1);
    chk({tag, "_wcomplete"}, wcomplete, 1);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_n_aw"}, wa_log.size(), N);
    chk({tag, "_n_w"}, wd_log.size(), N);
    chk({tag, "_n_b"}, bhs_cyc.size(), N);
    chk({tag, "_n_ar"}, ra_log.size(), N);
    chk({tag, "_n_r"}, rhs_cyc.size(), N);
    chk({tag, "_bready_pulses"}, bready_rises, N);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_awaddr"}, qw(wa_log, i), BASE + 32'(4 * i));
      chk({tag, "_wdata"}, qw(wd_log, i), START + 32'(i));
      chk({tag, "_araddr"}, qw(ra_log, i), BASE + 32'(4 * i));
    end
    chk({tag, "_wcomplete_cycle"}, wc_cyc, qi(bhs_cyc, N - 1) + 1);
    chk({tag, "_rcomplete_cycle"}, rc_cyc, qi(rhs_cyc, N - 1) + 1);
    chk({tag, "_done_idle"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
  endtask
  initial begin
    set_delays(0, 0, 0, 0, 0, 0);
    berr_idx = 99; rbad_idx = 99;
    #1 rst_n = 0;
    #2;
    chk("rst_outputs", {wcomplete, rcomplete, error, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_araddr", araddr, 0);
    do_reset();
    run_and_check("zero_wait", 0);
    set_delays(3, 3, 0, 0, 0, 0);
    do_reset();
    run_and_check("aw_delay3", 0);
    chk("aw_delay3_w_drops_first", w_first_drop, 1);
    set_delays(0, 3, 0, 3, 0, 3);
    berr_idx = 2;
    do_reset();
    run_and_check("bresp_err", 1);
    chk("bresp_err_cycle", err_cyc, qi(bhs_cyc, 2) + 1);
    berr_idx = 99; rbad_idx = 1;
    do_reset();
    run_and_check("rdata_bad", 1);
    chk("rdata_bad_cycle", err_cyc, qi(rhs_cyc, 1) + 1);
    for (int k = 0; k < 4; k++) begin
      set_delays(0, $urandom_range(0, 4), 0, $urandom_range(0, 4), 0, $urandom_range(0, 4));
      berr_idx = $urandom_range(0, 2 * N);
      rbad_idx = $urandom_range(0, 2 * N);
      do_reset();
      run_and_check("random", (berr_idx < N) || (rbad_idx < N));
    end
    set_delays(3, 3, 0, 0, 0, 0);
    berr_idx = 99; rbad_idx = 99;
    do_reset();
    for (int c = 0; c < 500 && !(bhs_cyc.size() == 1 && awvalid === 1'b1); c++) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_write1", awvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("mid_rst_flags", {wcomplete, rcomplete, error}, 0);
    chk("mid_rst_awaddr", awaddr, 0);
    chk("mid_rst_wdata", wdata, 0);
    set_delays(0, 2, 0, 2, 0, 2);
    do_reset();
    run_and_check("after_rst", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
